pc_redirect_ctrl: RTL

- Owns the architectural program counter for the 5-stage RISC-V pipeline.
- Consumes the branch-target result from the branch ALU in EX and steers instruction fetch.
- Advances the PC under the imem handshake, holds it on hazard stalls, and redirects it on a taken branch.
- Generates the IF/ID and ID/EX flush pulses that squash wrong-path instructions.
- PC is a word address: +1 per instruction, matching the branch target encoding.

---
 rtl/riscv_pipe_pkg.sv | 17 +
 rtl/pc_redirect_ctrl_if.sv | 46 ++++
 rtl/pc_redirect_ctrl_flush_timer.sv | 31 +++
 rtl/pc_redirect_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and constants for the PC redirect controller.
// Holds the XLEN, reset PC default, flush-counter width and FSM state type.
package riscv_pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int FLUSH_CNT_W = 4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } pc_state_e;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Fetch-steering bundle between the PC redirect controller and the pipeline.
// master = the controller, slave = hazard unit / imem / EX / pipeline regs.
interface pc_redirect_ctrl_if;
    import riscv_pipe_pkg::*;

    logic            stall;
    logic            imem_ready;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            flush_if_id;
    logic            flush_id_ex;
    logic            redirect_busy;
    logic [31:0]     redirect_count;
    logic [31:0]     flush_cycle_count;

    modport master (
        input  stall,
        input  imem_ready,
        input  branch_taken,
        input  branch_target,
        output pc,
        output pc_valid,
        output flush_if_id,
        output flush_id_ex,
        output redirect_busy,
        output redirect_count,
        output flush_cycle_count
    );

    modport slave (
        output stall,
        output imem_ready,
        output branch_taken,
        output branch_target,
        input  pc,
        input  pc_valid,
        input  flush_if_id,
        input  flush_id_ex,
        input  redirect_busy,
        input  redirect_count,
        input  flush_cycle_count
    );

endinterface

// File: rtl/pc_redirect_ctrl_flush_timer.sv
// Loadable down-counter with a terminal (zero) flag.
// Times how long the controller stays in its flush state.
module flush_timer
    import riscv_pipe_pkg::*;
#(
    parameter int W = FLUSH_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Architectural PC owner: advance, stall-hold, branch redirect and flushes.
// Optional perf counters enabled by macro PC_REDIRECT_PERF_CNT_EN.
module pc_redirect_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int              PC_STEP      = 1,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_redirect_ctrl_if.master   bus
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD =
        FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    pc_state_e         r_state;
    logic [XLEN-1:0]   r_pc;
    logic              r_pc_valid;
    logic              r_flush_if_id;
    logic              r_flush_id_ex;
    logic              r_busy;

    pc_state_e         w_next_state;
    logic [XLEN-1:0]   w_next_pc;
    logic              w_next_fif;
    logic              w_next_fex;
    logic              w_load;
    logic              w_dec;
    logic              w_zero;
    logic              w_redirect;

    flush_timer #(
        .W (FLUSH_CNT_W)
    ) u_flush_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (FLUSH_LOAD),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // Next-state and next-output decode for the BOOT/RUN/FLUSH machine.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_fif   = 1'b0;
        w_next_fex   = 1'b0;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_redirect   = 1'b0;
        unique case (r_state)
            S_BOOT: begin
                w_next_state = S_RUN;
            end
            S_RUN: begin
                if (bus.branch_taken) begin
                    w_next_state = S_FLUSH;
                    w_next_pc    = bus.branch_target;
                    w_next_fif   = 1'b1;
                    w_next_fex   = 1'b1;
                    w_load       = 1'b1;
                    w_redirect   = 1'b1;
                end else if (bus.stall || !bus.imem_ready) begin
                    w_next_pc = r_pc;
                end else begin
                    w_next_pc = r_pc + STEP;
                end
            end
            S_FLUSH: begin
                if (bus.imem_ready) begin
                    w_next_pc = r_pc + STEP;
                end
                if (w_zero) begin
                    w_next_state = S_RUN;
                end else begin
                    w_dec      = 1'b1;
                    w_next_fif = 1'b1;
                end
            end
            default: begin
                w_next_state = S_BOOT;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_pc_valid    <= 1'b0;
            r_flush_if_id <= 1'b0;
            r_flush_id_ex <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_pc          <= w_next_pc;
            r_pc_valid    <= 1'b1;
            r_flush_if_id <= w_next_fif;
            r_flush_id_ex <= w_next_fex;
            r_busy        <= (w_next_state == S_FLUSH);
        end
    end

    assign bus.pc            = r_pc;
    assign bus.pc_valid      = r_pc_valid;
    assign bus.flush_if_id   = r_flush_if_id;
    assign bus.flush_id_ex   = r_flush_id_ex;
    assign bus.redirect_busy = r_busy;

`ifdef PC_REDIRECT_PERF_CNT_EN
    logic [31:0] r_redirect_count;
    logic [31:0] r_flush_cycle_count;

    // Count accepted redirects and cycles spent with IF/ID squashed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect_count    <= '0;
            r_flush_cycle_count <= '0;
        end else begin
            if (w_redirect) begin
                r_redirect_count <= r_redirect_count + 32'd1;
            end
            if (r_flush_if_id) begin
                r_flush_cycle_count <= r_flush_cycle_count + 32'd1;
            end
        end
    end

    assign bus.redirect_count    = r_redirect_count;
    assign bus.flush_cycle_count = r_flush_cycle_count;
`else
    logic w_unused_redirect;

    assign w_unused_redirect     = w_redirect;
    assign bus.redirect_count    = 32'd0;
    assign bus.flush_cycle_count = 32'd0;
`endif

endmodule
